cordic_rotator: RTL

Iterative rotation-mode CORDIC engine: accepts one signed angle per transaction and produces its cosine and sine after ITER micro-rotations, one per clock. It is the direct consumer of the `get_radian` arctangent ROM. It drives the ROM address with its iteration counter and uses the 28-bit unsigned Q0.28 `atan(2^-i)` word for the angle-accumulator update. It sits between the angle source (phase accumulator / control logic) and the downstream sin/cos consumers, with valid/ready on both sides.

---
 rtl/cordic_rotator.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/cordic_rotator.sv
// Iterative rotation-mode CORDIC: one signed Q2.28 angle in, Q1.28 cosine/sine out
// after ITER micro-rotations. Includes the get_radian atan(2^-i) ROM it consumes.

module get_radian (
    input  logic [5:0]  i_address,
    output logic [27:0] o_radian
);
    // atan(2^-i) in unsigned Q0.28, rounded to nearest
    always_comb begin
        case (i_address)
            6'd0:    o_radian = 28'd210828714;
            6'd1:    o_radian = 28'd124459457;
            6'd2:    o_radian = 28'd65760959;
            6'd3:    o_radian = 28'd33381290;
            6'd4:    o_radian = 28'd16755422;
            6'd5:    o_radian = 28'd8385879;
            6'd6:    o_radian = 28'd4193963;
            6'd7:    o_radian = 28'd2097109;
            6'd8:    o_radian = 28'd1048571;
            6'd9:    o_radian = 28'd524287;
            6'd10:   o_radian = 28'd262144;
            6'd11:   o_radian = 28'd131072;
            6'd12:   o_radian = 28'd65536;
            6'd13:   o_radian = 28'd32768;
            6'd14:   o_radian = 28'd16384;
            6'd15:   o_radian = 28'd8192;
            6'd16:   o_radian = 28'd4096;
            6'd17:   o_radian = 28'd2048;
            6'd18:   o_radian = 28'd1024;
            6'd19:   o_radian = 28'd512;
            6'd20:   o_radian = 28'd256;
            6'd21:   o_radian = 28'd128;
            6'd22:   o_radian = 28'd64;
            6'd23:   o_radian = 28'd32;
            6'd24:   o_radian = 28'd16;
            6'd25:   o_radian = 28'd8;
            6'd26:   o_radian = 28'd4;
            6'd27:   o_radian = 28'd2;
            default: o_radian = 28'd0;
        endcase
    end
endmodule

// state | meaning
// IDLE  | waiting for an angle, in_ready high
// ROT   | one micro-rotation per clock, cnt addresses the ROM
// DONE  | result held on cos_out/sin_out until out_ready
module cordic_rotator #(
    parameter int ITER  = 28,
    parameter int KINIT = 163008219
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [30:0] theta,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [29:0] cos_out,
    output logic [29:0] sin_out,
    output logic        busy
);
    typedef enum logic [1:0] {IDLE, ROT, DONE} state_t;

    localparam logic signed [30:0] PI_HALF  = 31'sd421657428;
    localparam logic signed [30:0] PI       = 31'sd843314856;
    localparam logic signed [29:0] X_INIT   = 30'(KINIT);
    localparam logic [5:0]         CNT_LAST = 6'(ITER - 1);

    state_t             r_state;
    logic signed [29:0] r_x;
    logic signed [29:0] r_y;
    logic signed [30:0] r_z;
    logic [5:0]         r_cnt;
    logic [29:0]        r_cos;
    logic [29:0]        r_sin;
    logic               r_out_valid;
    logic               r_busy;

    logic [27:0]        w_atan;
    logic signed [30:0] w_theta;
    logic signed [30:0] w_z_step;
    logic signed [29:0] w_x_sh;
    logic signed [29:0] w_y_sh;
    logic signed [29:0] w_x_nxt;
    logic signed [29:0] w_y_nxt;
    logic signed [30:0] w_z_nxt;
    logic               w_dir_pos;

    get_radian u_rom (
        .i_address (r_cnt),
        .o_radian  (w_atan)
    );

    assign w_theta   = theta;
    assign w_z_step  = $signed({3'b000, w_atan});
    assign w_dir_pos = ~r_z[30];
    assign w_x_sh    = r_x >>> r_cnt;
    assign w_y_sh    = r_y >>> r_cnt;
    assign w_x_nxt   = w_dir_pos ? (r_x - w_y_sh)   : (r_x + w_y_sh);
    assign w_y_nxt   = w_dir_pos ? (r_y + w_x_sh)   : (r_y - w_x_sh);
    assign w_z_nxt   = w_dir_pos ? (r_z - w_z_step) : (r_z + w_z_step);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_x         <= '0;
            r_y         <= '0;
            r_z         <= '0;
            r_cnt       <= '0;
            r_cos       <= '0;
            r_sin       <= '0;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_state <= ROT;
                        r_busy  <= 1'b1;
                        r_cnt   <= '0;
                        r_y     <= '0;
                        // Fold outer half-plane angles by pi and negate the start vector
                        if (w_theta > PI_HALF) begin
                            r_z <= w_theta - PI;
                            r_x <= -X_INIT;
                        end else if (w_theta < -PI_HALF) begin
                            r_z <= w_theta + PI;
                            r_x <= -X_INIT;
                        end else begin
                            r_z <= w_theta;
                            r_x <= X_INIT;
                        end
                    end
                end
                ROT: begin
                    r_x <= w_x_nxt;
                    r_y <= w_y_nxt;
                    r_z <= w_z_nxt;
                    if (r_cnt == CNT_LAST) begin
                        r_cnt       <= '0;
                        r_cos       <= w_x_nxt;
                        r_sin       <= w_y_nxt;
                        r_out_valid <= 1'b1;
                        r_state     <= DONE;
                    end else begin
                        r_cnt <= r_cnt + 6'd1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_busy      <= 1'b0;
                        r_state     <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign in_ready  = (r_state == IDLE);
    assign out_valid = r_out_valid;
    assign busy      = r_busy;
    assign cos_out   = r_cos;
    assign sin_out   = r_sin;
endmodule
